// File: rtl/bin_to_bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin_to_bcd_seq
// Brief    : Sequential double-dabble converter. Converts an unsigned binary
//            value into packed BCD digits using one add-3/shift step per
//            clock, with a start/busy/done handshake and saturating overflow.
// Revision : 1.0 - initial release
// ============================================================================
module bin_to_bcd_seq #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      bin,
  output logic                  busy,
  output logic                  done,
  output logic                  ovf,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int c_BCD_W = 4 * DIGITS;
  localparam int c_CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  // Largest value representable in DIGITS decimal digits (10^DIGITS - 1).
  function automatic logic [63:0] f_max_val(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) begin
      p = p * 64'd10;
    end
    return p - 64'd1;
  endfunction

  // Saturation pattern: every digit set to 9.
  function automatic logic [c_BCD_W-1:0] f_all_nines();
    logic [c_BCD_W-1:0] r;
    r = '0;
    for (int i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'd9;
    end
    return r;
  endfunction

  localparam logic [63:0]         c_MAX      = f_max_val(DIGITS);
  localparam logic [c_BCD_W-1:0]  c_ALL9     = f_all_nines();
  localparam logic [c_CNT_W-1:0]  c_CNT_LAST = c_CNT_W'(BIN_W - 1);
  localparam logic [c_CNT_W-1:0]  c_CNT_ONE  = c_CNT_W'(1);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t               r_state;
  state_t               w_state_next;

  logic [BIN_W-1:0]     r_shreg;
  logic [c_BCD_W-1:0]   r_scr;
  logic [c_CNT_W-1:0]   r_cnt;
  logic                 r_ovf_pend;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_ovf;
  logic [c_BCD_W-1:0]   r_bcd;

  logic [c_BCD_W-1:0]   w_adj;
  logic [c_BCD_W-1:0]   w_scr_next;
  logic [BIN_W-1:0]     w_sh_next;
  logic                 w_carry;
  logic                 w_start_ok;
  logic                 w_last;
  logic                 w_over;
  logic                 w_sat;
  logic [63:0]          w_bin_ext;

  // Per-digit add-3 correction; digits are independent, no inter-digit carry.
  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    assign w_adj[4*g +: 4] = (r_scr[4*g +: 4] >= 4'd5) ? (r_scr[4*g +: 4] + 4'd3)
                                                       : r_scr[4*g +: 4];
  end

  // Shift {scratch, shreg} left by one; the shreg MSB enters the scratch LSB.
  assign w_scr_next = {w_adj[c_BCD_W-2:0], r_shreg[BIN_W-1]};
  assign w_carry    = w_adj[c_BCD_W-1];

  if (BIN_W > 1) begin : g_sh_wide
    assign w_sh_next = {r_shreg[BIN_W-2:0], 1'b0};
  end else begin : g_sh_one
    assign w_sh_next = 1'b0;
  end

  assign w_bin_ext  = 64'(bin);
  assign w_over     = (w_bin_ext > c_MAX);
  assign w_start_ok = (r_state == S_IDLE) && start;
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == '0);
  // A bit shifted out of the top digit can only occur for out-of-range input,
  // so folding it in keeps the saturation decision robust.
  assign w_sat      = r_ovf_pend | w_carry;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic: accept start only while idle, return after last step.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (start)  w_state_next = S_SHIFT;
      S_SHIFT: if (w_last) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // Datapath and registered outputs: capture, iterate, publish on last step.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shreg    <= '0;
      r_scr      <= '0;
      r_cnt      <= '0;
      r_ovf_pend <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_ovf      <= 1'b0;
      r_bcd      <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_ok) begin
        r_shreg    <= bin;
        r_scr      <= '0;
        r_cnt      <= c_CNT_LAST;
        r_ovf_pend <= w_over;
        r_busy     <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        r_shreg <= w_sh_next;
        r_scr   <= w_scr_next;
        if (w_last) begin
          r_cnt  <= '0;
          r_busy <= 1'b0;
          r_done <= 1'b1;
          r_ovf  <= w_sat;
          r_bcd  <= w_sat ? c_ALL9 : w_scr_next;
        end else begin
          r_cnt <= r_cnt - c_CNT_ONE;
        end
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_done;
  assign ovf     = r_ovf;
  assign bcd_out = r_bcd;

endmodule
`default_nettype wire
